// File: rtl/fta64_pkg.sv
// FTA 64-bit command bus payload types shared by initiators, responders and benches.
package fta64_pkg;

    localparam int unsigned CID_W = 4;
    localparam int unsigned TID_W = 4;

    typedef struct packed {
        logic [4:0]       cmd;
        logic [2:0]       sz;
        logic             cyc;
        logic             stb;
        logic             we;
        logic [CID_W-1:0] cid;
        logic [TID_W-1:0] tid;
        logic [31:0]      vadr;
        logic [31:0]      padr;
        logic [7:0]       sel;
        logic [63:0]      dat;
    } fta_cmd_request64_t;

    typedef struct packed {
        logic [CID_W-1:0] cid;
        logic [TID_W-1:0] tid;
        logic             ack;
        logic             err;
        logic             rty;
        logic [63:0]      dat;
    } fta_cmd_response64_t;

endpackage

// File: rtl/fta64_initiator.sv
// Single-outstanding FTA 64-bit initiator: one local command -> one FTA request,
// with retry on rty, error reporting and response timeout.
module fta64_initiator
    import fta64_pkg::*;
#(
    parameter int unsigned CID       = 1,
    parameter int unsigned TMO       = 1023,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic                cmd_we,
    input  logic [31:0]         cmd_adr,
    input  logic [7:0]          cmd_sel,
    input  logic [63:0]         cmd_dat,
    output logic                done,
    output logic                done_err,
    output logic                done_tmo,
    output logic [63:0]         done_dat,
    output fta_cmd_request64_t  req,
    input  fta_cmd_response64_t resp
);

    localparam int unsigned TW = ($clog2(TMO) > 10) ? $clog2(TMO) : 10;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state, state_n;
    logic [RW-1:0]    retry, retry_n;
    logic [TW-1:0]    tmo_cnt;
    logic [TID_W-1:0] tid;
    logic             cyc_q;
    logic             we_q;
    logic [7:0]       sel_q;
    logic [31:0]      adr_q;
    logic [63:0]      dat_q;
    logic [CID_W-1:0] cid_q;
    logic             accept;
    logic             match;
    logic             tmo_hit;
    logic             err_n;
    logic             tmo_n;
    logic             load_dat;

    assign accept  = cmd_vld & cmd_rdy;
    assign match   = resp.ack & (resp.cid == CID_W'(CID)) & (resp.tid == tid);
    // Count is cleared in REQ and advances in WAIT; this is the cycle it steps onto TMO-1.
    assign tmo_hit = (tmo_cnt == TW'(TMO - 2));

    // Request bus is pure wiring from the captured command registers.
    always_comb begin
        req      = '0;
        req.cyc  = cyc_q;
        req.we   = we_q;
        req.sel  = sel_q;
        req.padr = adr_q;
        req.dat  = dat_q;
        req.cid  = cid_q;
        req.tid  = tid;
    end

    // Next state and completion status; a match in REQ is resolved immediately.
    always_comb begin
        state_n  = state;
        retry_n  = retry;
        err_n    = 1'b0;
        tmo_n    = 1'b0;
        load_dat = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    retry_n = '0;
                    state_n = REQ;
                end
            end
            REQ, WAIT: begin
                if (match) begin
                    if (resp.err) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else if (resp.rty) begin
                        if (retry < RW'(MAX_RETRY)) begin
                            retry_n = retry + RW'(1);
                            state_n = REQ;
                        end else begin
                            state_n = DONE;
                            err_n   = 1'b1;
                        end
                    end else begin
                        state_n  = DONE;
                        load_dat = ~we_q;
                    end
                end else if (state == REQ) begin
                    state_n = WAIT;
                end else if (tmo_hit) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    tmo_n   = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control registers and registered handshake/strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            retry    <= '0;
            tmo_cnt  <= '0;
            tid      <= '0;
            cmd_rdy  <= 1'b1;
            cyc_q    <= 1'b0;
            done     <= 1'b0;
            done_err <= 1'b0;
            done_tmo <= 1'b0;
        end else begin
            state    <= state_n;
            retry    <= retry_n;
            cmd_rdy  <= (state_n == IDLE);
            cyc_q    <= (state_n == REQ);
            done     <= (state_n == DONE);
            done_err <= err_n;
            done_tmo <= tmo_n;
            if (state == REQ) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (state == DONE) begin
                tid <= tid + TID_W'(1);
            end
        end
    end

    // Command capture at accept and read-data return on a successful read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            cid_q    <= '0;
            done_dat <= '0;
        end else begin
            if (accept) begin
                we_q  <= cmd_we;
                sel_q <= cmd_sel;
                adr_q <= cmd_adr;
                dat_q <= cmd_dat;
                cid_q <= CID_W'(CID);
            end
            if (load_dat) begin
                done_dat <= resp.dat;
            end
        end
    end

endmodule

// File: tb/tb_fta64_initiator.sv
// Directed bench for fta64_initiator: scripted responder, transaction-level
// timeline model, per-cycle compare plus literal spot checks.
module tb_fta64_initiator;
    import fta64_pkg::*;

    localparam int unsigned CID_P = 1;
    localparam int unsigned TMO_P = 16;
    localparam int unsigned MAX_P = 3;
    localparam int K_NONE = 0;
    localparam int K_OK   = 1;
    localparam int K_RTY  = 2;
    localparam int K_ERR  = 3;

    logic                clk;
    logic                rst;
    logic                cmd_vld;
    logic                cmd_rdy;
    logic                cmd_we;
    logic [31:0]         cmd_adr;
    logic [7:0]          cmd_sel;
    logic [63:0]         cmd_dat;
    logic                done;
    logic                done_err;
    logic                done_tmo;
    logic [63:0]         done_dat;
    fta_cmd_request64_t  req;
    fta_cmd_response64_t resp;

    fta64_initiator #(.CID(CID_P), .TMO(TMO_P), .MAX_RETRY(MAX_P)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
        .done(done), .done_err(done_err), .done_tmo(done_tmo), .done_dat(done_dat),
        .req(req), .resp(resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;
    int cyc_n;

    // Expected timeline, keyed by absolute cycle number.
    bit          issue_at[int];
    bit          rdy_low[int];
    bit          done_at[int];
    bit          derr_at[int];
    bit          dtmo_at[int];
    logic [63:0] dat_at[int];
    logic [63:0] cur_dat;

    logic        exp_we;
    logic [7:0]  exp_sel;
    logic [31:0] exp_padr;
    logic [63:0] exp_dat;
    logic [3:0]  exp_tid;
    logic [3:0]  model_tid;
    int          acc_cyc;
    int          done_cyc;

    // Responder script for the current transaction.
    int          scr_kind[4];
    int          scr_dly[4];
    logic [63:0] scr_rdat;
    int          issue_k;
    bit          pend_v;
    int          pend_cyc;
    int          pend_kind;
    logic [3:0]  pend_tid;
    int          n_stray;
    int          stray_cyc[8];
    logic [3:0]  stray_tid[8];
    logic [3:0]  stray_cid[8];

    // Observations of the DUT for literal spot checks.
    int          obs_iss;
    int          obs_done_cyc;
    int          obs_done_n;
    logic        obs_err;
    logic        obs_tmo;
    logic [3:0]  obs_tid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic compare();
        int   c;
        logic exp_rdy;
        logic exp_cyc;
        logic exp_done;
        c = cyc_n;
        if (dat_at.exists(c) != 0) cur_dat = dat_at[c];
        exp_rdy  = (rdy_low.exists(c) == 0);
        exp_cyc  = (issue_at.exists(c) != 0);
        exp_done = (done_at.exists(c) != 0);
        check("cmd_rdy", 64'(cmd_rdy), 64'(exp_rdy));
        check("req_cyc", 64'(req.cyc), 64'(exp_cyc));
        if (exp_cyc) begin
            check("req_we", 64'(req.we), 64'(exp_we));
            check("req_sel", 64'(req.sel), 64'(exp_sel));
            check("req_padr", 64'(req.padr), 64'(exp_padr));
            check("req_dat", req.dat, exp_dat);
            check("req_cid", 64'(req.cid), 64'(CID_P));
            check("req_tid", 64'(req.tid), 64'(exp_tid));
            check("req_other", 64'({req.cmd, req.sz, req.stb, req.vadr}), 64'(0));
        end
        check("done", 64'(done), 64'(exp_done));
        if (exp_done) begin
            check("done_err", 64'(done_err), 64'(derr_at[c]));
            check("done_tmo", 64'(done_tmo), 64'(dtmo_at[c]));
        end
        check("done_dat", done_dat, cur_dat);
        if (cmd_vld && cmd_rdy) obs_iss = 0;
        if (req.cyc) begin
            obs_iss++;
            obs_tid = req.tid;
        end
        if (done) begin
            obs_done_cyc = c;
            obs_done_n++;
            obs_err = done_err;
            obs_tmo = done_tmo;
        end
    endtask

    // Behavioural responder: echoes the request tid after a scripted delay.
    task automatic respond();
        resp = '0;
        if (rst) begin
            pend_v = 1'b0;
        end else begin
            if (req.cyc) begin
                if (issue_k < 4 && scr_kind[issue_k] != K_NONE) begin
                    pend_v    = 1'b1;
                    pend_cyc  = cyc_n + scr_dly[issue_k];
                    pend_kind = scr_kind[issue_k];
                    pend_tid  = req.tid;
                end
                issue_k++;
            end
            if (pend_v && pend_cyc == cyc_n) begin
                resp.ack = 1'b1;
                resp.cid = 4'(CID_P);
                resp.tid = pend_tid;
                resp.err = (pend_kind == K_ERR);
                resp.rty = (pend_kind == K_RTY);
                resp.dat = (pend_kind == K_OK) ? scr_rdat : ~scr_rdat;
                pend_v   = 1'b0;
            end else begin
                for (int i = 0; i < n_stray; i++) begin
                    if (stray_cyc[i] == cyc_n) begin
                        resp.ack = 1'b1;
                        resp.cid = stray_cid[i];
                        resp.tid = stray_tid[i];
                        resp.dat = 64'hDEAD_DEAD_DEAD_DEAD;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        cyc_n++;
        #1;
        respond();
    endtask

    task automatic set_script(input int k0, input int d0, input int k1, input int d1,
                              input int k2, input int d2, input int k3, input int d3);
        scr_kind[0] = k0; scr_dly[0] = d0;
        scr_kind[1] = k1; scr_dly[1] = d1;
        scr_kind[2] = k2; scr_dly[2] = d2;
        scr_kind[3] = k3; scr_dly[3] = d3;
    endtask

    task automatic add_stray(input int cy, input logic [3:0] tid, input logic [3:0] cid);
        if (n_stray < 8) begin
            stray_cyc[n_stray] = cy;
            stray_tid[n_stray] = tid;
            stray_cid[n_stray] = cid;
            n_stray++;
        end
    endtask

    // Present a command this cycle and predict its whole timeline from the script.
    task automatic start_txn(input logic we, input logic [31:0] adr, input logic [7:0] sel,
                             input logic [63:0] dat, input logic [63:0] rdat, input bit keep);
        int c, i, k, a, d;
        bit fin, e, t;
        c = cyc_n;
        acc_cyc = c;
        cmd_vld = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
        scr_rdat = rdat;
        issue_k  = 0;
        pend_v   = 1'b0;
        exp_we = we; exp_sel = sel; exp_padr = adr; exp_dat = dat; exp_tid = model_tid;
        i = c + 1; k = 0; d = 0; fin = 1'b0; e = 1'b0; t = 1'b0;
        while (!fin) begin
            issue_at[i] = 1'b1;
            if (scr_kind[k] == K_NONE || scr_dly[k] > int'(TMO_P) - 1) begin
                d = i + int'(TMO_P); e = 1'b1; t = 1'b1; fin = 1'b1;
            end else begin
                a = i + scr_dly[k];
                if (scr_kind[k] == K_ERR) begin
                    d = a + 1; e = 1'b1; fin = 1'b1;
                end else if (scr_kind[k] == K_RTY) begin
                    if (k < int'(MAX_P)) begin
                        k++; i = a + 1;
                    end else begin
                        d = a + 1; e = 1'b1; fin = 1'b1;
                    end
                end else begin
                    d = a + 1; fin = 1'b1;
                    if (!we) dat_at[d] = rdat;
                end
            end
        end
        for (int j = c + 1; j <= d; j++) rdy_low[j] = 1'b1;
        done_at[d] = 1'b1; derr_at[d] = e; dtmo_at[d] = t;
        done_cyc  = d;
        model_tid = model_tid + 4'd1;
        tick();
        if (keep) begin
            cmd_we = ~we; cmd_adr = 32'hBAD0_0000; cmd_sel = ~sel; cmd_dat = ~dat;
        end else begin
            cmd_vld = 1'b0;
        end
    endtask

    task automatic finish_txn();
        while (cyc_n <= done_cyc) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue_at.delete(); rdy_low.delete(); done_at.delete();
        derr_at.delete(); dtmo_at.delete(); dat_at.delete();
        dat_at[cyc_n] = 64'd0;
        model_tid = 4'd0;
        pend_v  = 1'b0;
        n_stray = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int         n_before;
        logic [3:0] old_tid;
        errors = 0; checks = 0; cyc_n = 0; cur_dat = '0; model_tid = '0;
        n_stray = 0; issue_k = 0; pend_v = 1'b0; pend_cyc = 0; pend_kind = 0; pend_tid = '0;
        obs_iss = 0; obs_done_cyc = 0; obs_done_n = 0; obs_err = 1'b0; obs_tmo = 1'b0; obs_tid = '0;
        acc_cyc = 0; done_cyc = 0; scr_rdat = '0;
        exp_we = 1'b0; exp_sel = '0; exp_padr = '0; exp_dat = '0; exp_tid = '0;
        set_script(K_NONE, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
        rst = 1'b1; cmd_vld = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_dat = '0;
        resp = '0;
        tick();
        tick();
        check("rst_req_zero", 64'(req == '0), 64'(1));
        check("rst_rdy", 64'(cmd_rdy), 64'(1));
        rst = 1'b0;
        tick();

        // Write to a combinational responder.
        set_script(K_OK, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
        start_txn(1'b1, 32'hFFDC_0600, 8'hFF, 64'h5A, 64'h0, 1'b0);
        finish_txn();
        check("t1_latency", 64'(obs_done_cyc - acc_cyc), 64'(2));
        check("t1_tid", 64'(obs_tid), 64'(0));
        check("t1_err", 64'(obs_err), 64'(0));

        // Read acked 5 cycles late, with a wrong-tid and a wrong-cid stray ack.
        add_stray(cyc_n + 4, 4'h9, 4'(CID_P));
        add_stray(cyc_n + 3, model_tid, 4'h2);
        set_script(K_OK, 5, K_NONE, 0, K_NONE, 0, K_NONE, 0);
        start_txn(1'b0, 32'h0000_2000, 8'hFF, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
        finish_txn();
        check("t2_dat", done_dat, 64'h1122_3344_5566_7788);
        check("t2_latency", 64'(obs_done_cyc - acc_cyc), 64'(7));
        check("t2_tid", 64'(obs_tid), 64'(1));

        // Two retries then success.
        set_script(K_RTY, 1, K_RTY, 1, K_OK, 1, K_NONE, 0);
        start_txn(1'b0, 32'h0000_2008, 8'hF0, 64'h0, 64'hCAFE_F00D_0BAD_BEEF, 1'b0);
        finish_txn();
        check("t3_issues", 64'(obs_iss), 64'(3));
        check("t3_err", 64'(obs_err), 64'(0));
        check("t3_dat", done_dat, 64'hCAFE_F00D_0BAD_BEEF);

        // Retry on every issue: exhaustion.
        set_script(K_RTY, 0, K_RTY, 0, K_RTY, 0, K_RTY, 0);
        start_txn(1'b1, 32'h0000_3000, 8'h0F, 64'h1234, 64'h0, 1'b0);
        finish_txn();
        check("t4_issues", 64'(obs_iss), 64'(4));
        check("t4_err", 64'(obs_err), 64'(1));
        check("t4_tmo", 64'(obs_tmo), 64'(0));

        // No response: timeout.
        set_script(K_NONE, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
        start_txn(1'b1, 32'h0000_4000, 8'hFF, 64'h77, 64'h0, 1'b0);
        old_tid = exp_tid;
        finish_txn();
        check("t5_tmo_latency", 64'(obs_done_cyc - (acc_cyc + 1)), 64'(16));
        check("t5_err", 64'(obs_err), 64'(1));
        check("t5_tmo", 64'(obs_tmo), 64'(1));

        // Late acks for the abandoned tid, while idle and during the next read.
        add_stray(cyc_n, old_tid, 4'(CID_P));
        add_stray(cyc_n + 3, old_tid, 4'(CID_P));
        n_before = obs_done_n;
        set_script(K_OK, 6, K_NONE, 0, K_NONE, 0, K_NONE, 0);
        start_txn(1'b0, 32'h0000_5000, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
        finish_txn();
        check("t6_one_done", 64'(obs_done_n - n_before), 64'(1));
        check("t6_dat", done_dat, 64'h0123_4567_89AB_CDEF);

        // Error response: no retry.
        set_script(K_ERR, 2, K_OK, 0, K_OK, 0, K_OK, 0);
        start_txn(1'b0, 32'h0000_6000, 8'hFF, 64'h0, 64'h5555_AAAA_5555_AAAA, 1'b0);
        finish_txn();
        check("t7_err", 64'(obs_err), 64'(1));
        check("t7_tmo", 64'(obs_tmo), 64'(0));
        check("t7_issues", 64'(obs_iss), 64'(1));
        check("t7_dat_kept", done_dat, 64'h0123_4567_89AB_CDEF);

        // Reset while waiting for a response.
        set_script(K_NONE, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
        start_txn(1'b1, 32'h0000_7000, 8'hFF, 64'h99, 64'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        n_before = obs_done_n;
        do_reset();
        check("t8_rdy", 64'(cmd_rdy), 64'(1));
        check("t8_cyc", 64'(req.cyc), 64'(0));
        check("t8_dat", done_dat, 64'(0));
        for (int i = 0; i < 20; i++) tick();
        check("t8_no_done", 64'(obs_done_n - n_before), 64'(0));

        // 17 back-to-back writes with cmd_vld held high and junk while busy.
        for (int i = 0; i < 17; i++) begin
            set_script(K_OK, 0, K_NONE, 0, K_NONE, 0, K_NONE, 0);
            start_txn(1'b1, 32'h0000_1000 + 32'(i * 8), 8'h0F, 64'(i), 64'h0, i < 16);
            finish_txn();
            check("t9_tid", 64'(obs_tid), 64'(i % 16));
            check("t9_latency", 64'(obs_done_cyc - acc_cyc), 64'(2));
        end
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
